// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, instruction register and field split with valid/ready hand-off; FETCH_COUNT_EN adds fetch_count.
module instruction_fetch #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] inst_address,
    input  logic [DATA_W-1:0] read_data,
    input  logic              fetch_en,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] ir_pc,
    output logic [DATA_W-1:0] ir,
    output logic [2:0]        opcode,
    output logic [3:0]        rs,
    output logic [3:0]        rt,
    output logic [3:0]        rd,
    output logic [15:0]       imm
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0]       fetch_count
`endif
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt, ir_pc_nxt;
    logic [DATA_W-1:0] ir_nxt;
    logic              valid_nxt, do_fetch;
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_pc_nxt = ir_pc;
        ir_nxt    = ir;
        valid_nxt = ir_valid;
        do_fetch  = 1'b0;
        unique case (state)
            IDLE: state_nxt = fetch_en ? FETCH : IDLE;
            FETCH: begin
                // a redirect in FETCH squashes this word; the target is fetched next cycle
                if (!branch_taken) begin
                    do_fetch  = 1'b1;
                    ir_nxt    = read_data;
                    ir_pc_nxt = pc;
                    pc_nxt    = pc + ADDR_W'(1);
                    valid_nxt = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (ir_ready || branch_taken) begin
                    valid_nxt = 1'b0;
                    state_nxt = fetch_en ? FETCH : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (branch_taken) pc_nxt = branch_target;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= ADDR_W'(RESET_PC);
            ir_pc    <= '0;
            ir       <= '0;
            ir_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            ir_pc    <= ir_pc_nxt;
            ir       <= ir_nxt;
            ir_valid <= valid_nxt;
        end
    end
`ifdef FETCH_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fetch_count <= '0;
        else if (do_fetch) fetch_count <= fetch_count + 32'd1;
    end
`endif
    assign inst_address = pc;
    assign opcode       = ir[31:29];
    assign rs           = ir[27:24];
    assign rt           = ir[23:20];
    assign rd           = ir[15:12];
    assign imm          = ir[15:0];
endmodule
